// File: rtl/pulse_spacer.sv
`default_nettype none
// ============================================================================
//  pulse_spacer : backlogs event strobes and re-emits them as one-cycle
//                 pulses spaced at least MIN_GAP cycles apart.
//  Revision     : 1.0
// ============================================================================
module pulse_spacer #(
  parameter int MIN_GAP   = 6,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 event_in,
  input  logic                 clear_overflow,
  output logic                 pulse_out,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [0:0]           ST_IDLE  = 1'b0;
  localparam logic [0:0]           ST_HOLD  = 1'b1;
  localparam logic [7:0]           GAP_LOAD = 8'(MIN_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [7:0]           r_timer;
  logic [CNT_WIDTH-1:0] r_pending;
  logic                 r_overflow;
  logic                 r_pulse;
  logic                 w_fire;
  logic                 w_accept;
  logic                 w_drop;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: HOLD ends on the edge where the timer reaches zero
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fire) w_state_next = ST_HOLD;
      ST_HOLD: if (r_timer == 8'd1) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output/decode logic, all from registered state
  always_comb begin
    w_fire   = (r_state == ST_IDLE) && (r_pending != '0);
    w_accept = event_in && ((r_pending != PEND_MAX) || w_fire);
    w_drop   = event_in && !w_accept;
    busy     = (r_pending != '0) || (r_timer != 8'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= 8'd0;
    end else if (w_fire) begin
      r_timer <= GAP_LOAD;
    end else if (r_timer != 8'd0) begin
      r_timer <= r_timer - 8'd1;
    end
  end

  // Simultaneous accept and fire leave the count unchanged, so it never wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      case ({w_accept, w_fire})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_fire;
    end
  end

  assign pulse_out = r_pulse;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pulse_spacer.sv
`default_nettype none
// ============================================================================
//  tb_pulse_spacer : scoreboard bench for pulse_spacer with a cycle-count model.
//  Revision        : 1.0
// ============================================================================
module tb_pulse_spacer;

  localparam int MIN_GAP   = 6;
  localparam int CNT_WIDTH = 2;
  localparam int PEND_MAX  = (1 << CNT_WIDTH) - 1;
  localparam int DRAIN     = MIN_GAP * (PEND_MAX + 2);

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 event_in = 1'b0;
  logic                 clear_overflow = 1'b0;
  logic                 pulse_out;
  logic [CNT_WIDTH-1:0] pending;
  logic                 overflow;
  logic                 busy;

  typedef struct packed {
    logic                 pulse;
    logic [CNT_WIDTH-1:0] pend;
    logic                 ovf;
    logic                 busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: pulse spacing measured as edges since the last fire
  int m_pend, m_cycle, m_last, ev_cnt, drop_cnt, dut_pulses;
  bit m_ovf;

  always #5 clk = ~clk;

  pulse_spacer #(.MIN_GAP(MIN_GAP), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .event_in       (event_in),
    .clear_overflow (clear_overflow),
    .pulse_out      (pulse_out),
    .pending        (pending),
    .overflow       (overflow),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pend   = 0;
    m_ovf    = 1'b0;
    m_cycle  = 0;
    m_last   = -1000;
    ev_cnt   = 0;
    drop_cnt = 0;
  endtask

  task automatic push_zero();
    exp_t e;
    e = '0;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit ev, input bit clr);
    exp_t e;
    bit   fire, acc;
    @(negedge clk);
    #1;
    reset_n        = 1'b1;
    event_in       = ev;
    clear_overflow = clr;
    fire = (m_pend > 0) && (m_cycle - m_last >= MIN_GAP);
    if (fire) m_last = m_cycle;
    acc = ev && ((m_pend < PEND_MAX) || fire);
    if (ev) ev_cnt++;
    if (ev && !acc) begin
      drop_cnt++;
      m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    m_pend = m_pend + int'(acc) - int'(fire);
    e.pulse = fire;
    e.pend  = CNT_WIDTH'(m_pend);
    e.ovf   = m_ovf;
    e.busy  = (m_pend != 0) || (m_cycle - m_last < MIN_GAP - 1);
    exp_q.push_back(e);
    m_cycle++;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, held across one full edge
  task automatic async_reset();
    @(negedge clk);
    #1;
    reset_n        = 1'b0;
    event_in       = 1'b0;
    clear_overflow = 1'b0;
    #1;
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    push_zero();
    @(negedge clk);
    #1;
    push_zero();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) dut_pulses = 0;
      else if (pulse_out === 1'b1) dut_pulses++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_out", 32'(pulse_out), 32'(e.pulse));
        check("pending", 32'(pending), 32'(e.pend));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("busy", 32'(busy), 32'(e.busy));
      end
    end
  end

  initial begin : driver
    int density, len;
    dut_pulses = 0;
    model_reset();
    @(negedge clk); #1; push_zero();
    @(negedge clk); #1; push_zero();

    // Single event, burst of three, saturation
    cycle(1'b1, 1'b0); drain(10);
    repeat (3) cycle(1'b1, 1'b0); drain(20);
    repeat (6) cycle(1'b1, 1'b0); drain(DRAIN);

    // Clear colliding with a dropped event, then clear alone
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    drain(DRAIN);

    // Reset while a backlog is held in HOLD
    repeat (4) cycle(1'b1, 1'b0);
    async_reset();
    drain(10);

    // Event arriving during HOLD
    cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0); drain(15);

    for (int it = 0; it < 40; it++) begin
      density = $urandom_range(4, 0);
      len     = $urandom_range(40, 5);
      for (int c = 0; c < len; c++)
        cycle($urandom_range(3, 0) < density, $urandom_range(15, 0) == 0);
      if ($urandom_range(9, 0) == 0) async_reset();
      if ($urandom_range(1, 0) == 0) drain(DRAIN);
    end

    drain(DRAIN);
    @(negedge clk);
    #2;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("pulses_plus_drops", 32'(dut_pulses + drop_cnt), 32'(ev_cnt));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_spacer.md
Name: pulse_spacer

Overview:
- Sits in the source clock domain directly upstream of the cross-domain pulse synchronizer.
- Accepts single-cycle event strobes at any rate, including back-to-back, and keeps a saturating backlog count.
- Re-emits the events as one-cycle pulses. Consecutive pulses start no less than MIN_GAP cycles apart.
- This spacing guarantees the downstream synchronizer sees isolated rising edges separated by enough cycles to complete its handshake.

Parameters:
- MIN_GAP, 6: cycles from one pulse_out assertion to the next; legal range 2..255.
- CNT_WIDTH, 8: width of backlog counter; max backlog 2^CNT_WIDTH-1.

Ports:
- clk  input  1  block clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- event_in  input  1  one event per cycle when high; level held N cycles = N events.
- clear_overflow  input  1  clears sticky overflow flag.
- pulse_out  output  1  registered single-cycle pulse, one per accepted event; feeds synchronizer pulse input.
- pending  output  CNT_WIDTH  events accepted but not yet emitted.
- overflow  output  1  sticky; set when an event is dropped due to saturation.
- busy  output  1  high when pending != 0 or spacing timer != 0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pulse_out=0, pending=0, overflow=0, gap timer=0, FSM=IDLE.
  - Mid-operation reset discards the backlog and any in-progress spacing.
  - No pulse is emitted on reset release.
- Gap timer:
  - 8-bit down-counter.
  - Loaded with MIN_GAP-1 on the edge that fires.
  - Decrements by 1 per cycle while nonzero.
- FSM states:
  - IDLE: timer=0. Fire condition is pending!=0, evaluated on the registered value.
  - HOLD: timer>0. No firing. Go to IDLE on the edge where the timer reaches 0.
- Fire edge, taken when in IDLE with pending!=0:
  - pulse_out<=1, timer<=MIN_GAP-1, pending decrements, FSM<=HOLD.
  - pulse_out is 1 for exactly one cycle; it is 0 on every non-fire edge.
- Latency:
  - event_in sampled high at edge k with pending=0 and IDLE: pending=1 after edge k; pulse_out=1 after edge k+1.
  - With a backlog, pulses appear after edges k+1, k+1+MIN_GAP, k+1+2*MIN_GAP, ...
- Counter update each edge: pending_next = pending + accept - fire.
  - Event and fire on the same edge: pending unchanged, event accepted.
  - Event at pending = 2^CNT_WIDTH-1 with no fire that edge: event dropped, pending held, overflow<=1.
  - Event at max with a fire that edge: accepted, pending held at max.
  - pending never wraps.
- overflow:
  - Set has priority over clear_overflow on the same edge.
  - clear_overflow alone: overflow<=0 next edge.
- busy is combinational from registered state.
- Spacing guarantee: with MIN_GAP>=2, pulse_out always has at least MIN_GAP-1 low cycles between highs.
- Invariant for the bench: total pulses emitted + events dropped = total events_in sampled high since reset.

Test Plan:
- Single event, MIN_GAP=6: event_in high 1 cycle at edge 0.
  -> pulse_out high after edge 1 only; pending 1->0; busy low after edge 6.
- Burst of 3, MIN_GAP=6: event_in high edges 0-2.
  -> pulse_out high after edges 1, 7, 13; pending sequence 1,1,2,2,...,1,...,0; overflow=0.
- Saturation, CNT_WIDTH=2: event_in high edges 0-5.
  -> pending reaches 3 after edge 3; overflow=1 after edge 4; 4 pulses total (edges 1, 7, 13, 19); 2 events dropped.
- Overflow set/clear collision: clear_overflow asserted on the same edge as a dropped event.
  -> overflow remains 1; clear on the next edge alone -> overflow=0.
- Reset mid-backlog: pending=3 in HOLD, reset_n pulsed low asynchronously between edges.
  -> all outputs 0 immediately; no pulse_out after release until a new event arrives.
- Event during HOLD, MIN_GAP=4: pulse fires at edge 1, event arrives at edge 2.
  -> next pulse after edge 5, not earlier; spacing exactly 4.
